// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Brief    : Prioritized 8-source interrupt controller that drives the MCU's INT_R.
//            Optional macro INTC_SYNC_EN adds a 2-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl #(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] BASE_ADDR = 8'h30,
  parameter int         HOLDOFF   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               io_strb,
  output logic [7:0]         in_port_data,
  output logic               rd_hit,
  output logic               int_r
);

  localparam logic [3:0] c_hold_init = (HOLDOFF == 0) ? 4'd0 : 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] w_irq_s;
  logic [NUM_SRC-1:0] r_irq_d;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] w_masked;
  logic [NUM_SRC-1:0] w_wr_data;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [7:0]         w_offset;
  logic               w_wr_status;
  logic               w_wr_mask;
  logic               w_wr_force;
  logic               w_active;
  logic [7:0]         w_vector;
  logic [7:0]         w_status_rd;
  logic [7:0]         w_mask_rd;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] r_sync_meta;
  logic [NUM_SRC-1:0] r_sync_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= '0;
      r_sync_out  <= '0;
    end else begin
      r_sync_meta <= irq_in;
      r_sync_out  <= r_sync_meta;
    end
  end

  assign w_irq_s = r_sync_out;
`else
  assign w_irq_s = irq_in;
`endif

  // Offset arithmetic wraps, so a window near 8'hFF still decodes correctly.
  assign w_offset    = port_id - BASE_ADDR;
  assign rd_hit      = (w_offset[7:2] == 6'd0);
  assign w_wr_status = io_strb && rd_hit && (w_offset[1:0] == 2'd0);
  assign w_wr_mask   = io_strb && rd_hit && (w_offset[1:0] == 2'd1);
  assign w_wr_force  = io_strb && rd_hit && (w_offset[1:0] == 2'd3);
  assign w_wr_data   = out_port[NUM_SRC-1:0];

  assign w_rise = w_irq_s & ~r_irq_d;
  assign w_clr  = w_wr_status ? w_wr_data : '0;
  assign w_set  = w_rise | (w_wr_force ? w_wr_data : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_d   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_irq_d   <= w_irq_s;
      // Set terms are OR'd last so a same-cycle event beats a clear.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr_mask) begin
        r_mask <= w_wr_data;
      end
    end
  end

  assign w_masked = r_pending & r_mask;
  assign w_active = |w_masked;

  always_comb begin
    w_vector = 8'hFF;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_vector = 8'(i);
      end
    end
  end

  always_comb begin
    w_status_rd                = 8'h00;
    w_status_rd[NUM_SRC-1:0]   = r_pending;
    w_mask_rd                  = 8'h00;
    w_mask_rd[NUM_SRC-1:0]     = r_mask;
    in_port_data               = 8'h00;
    if (rd_hit) begin
      case (w_offset[1:0])
        2'd0:    in_port_data = w_status_rd;
        2'd1:    in_port_data = w_mask_rd;
        2'd2:    in_port_data = w_vector;
        default: in_port_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_active) begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!w_active) begin
          if (HOLDOFF == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = c_hold_init;
          end
        end
      end
      ST_HOLD: begin
        // Holdoff gives RETIE time to complete before a new request.
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign int_r = (r_state == ST_ASSERT);

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl
// Brief    : Randomized scoreboard bench for intr_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

  localparam int         HOLDOFF = 4;
  localparam logic [7:0] A_STAT  = 8'h30;
  localparam logic [7:0] A_MASK  = 8'h31;
  localparam logic [7:0] A_VEC   = 8'h32;
  localparam logic [7:0] A_FORCE = 8'h33;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       io_strb = 1'b0;
  logic [7:0] in_port_data;
  logic       rd_hit;
  logic       int_r;

  intr_ctrl #(
    .NUM_SRC   (8),
    .BASE_ADDR (8'h30),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .port_id      (port_id),
    .out_port     (out_port),
    .io_strb      (io_strb),
    .in_port_data (in_port_data),
    .rd_hit       (rd_hit),
    .int_r        (int_r)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       int_r;
    logic       rd_hit;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: pending/mask sets, request flag, and remaining quiet cycles.
  bit [7:0] m_pend, m_mask, m_prev;
  bit [7:0] m_pipe0, m_pipe1;
  bit       m_req;
  int       m_quiet;

  function automatic void model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_pipe0 = 0; m_pipe1 = 0;
    m_req = 0; m_quiet = 0;
  endfunction

  function automatic void model_step();
    bit [7:0] ev;
    bit [7:0] rise;
    bit       act;
    int       off;
    if (rst) begin
      model_reset();
      return;
    end
    act = (m_pend & m_mask) != 0;
    if (m_req) begin
      if (!act) begin
        m_req   = 0;
        m_quiet = HOLDOFF;
      end
    end else if (m_quiet > 0) begin
      m_quiet = m_quiet - 1;
    end else if (act) begin
      m_req = 1;
    end
`ifdef INTC_SYNC_EN
    ev      = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = irq_in;
`else
    ev = irq_in;
`endif
    rise   = ev & ~m_prev;
    m_prev = ev;
    off    = int'(port_id) - int'(A_STAT);
    if (io_strb && off == 0) m_pend = m_pend & ~out_port;
    if (io_strb && off == 3) m_pend = m_pend | out_port;
    if (io_strb && off == 1) m_mask = out_port;
    m_pend = m_pend | rise;
  endfunction

  function automatic exp_t model_out();
    exp_t     e;
    int       off;
    bit [7:0] masked;
    off      = int'(port_id) - int'(A_STAT);
    masked   = m_pend & m_mask;
    e.int_r  = m_req;
    e.rd_hit = (off >= 0) && (off <= 3);
    e.data   = 8'h00;
    if (off == 0) e.data = m_pend;
    else if (off == 1) e.data = m_mask;
    else if (off == 2) begin
      e.data = 8'hFF;
      for (int i = 0; i < 8; i++) begin
        if (masked[i]) begin
          e.data = 8'(i);
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic cycle(input bit r, input bit [7:0] irq, input bit s,
                       input bit [7:0] pid, input bit [7:0] d);
    @(posedge clk);
    model_step();
    #1;
    rst = r; irq_in = irq; io_strb = s; port_id = pid; out_port = d;
    if (r) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h (port_id %h)", nm, $time, got, want, port_id);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("int_r", {7'd0, int_r}, {7'd0, e.int_r});
      chk("rd_hit", {7'd0, rd_hit}, {7'd0, e.rd_hit});
      chk("in_port_data", in_port_data, e.data);
    end
  end

  initial begin
    bit [7:0] irq_v;
    bit [7:0] pid;
    model_reset();
    // Reset state
    cycle(1, 8'h00, 0, A_STAT, 8'h00);
    cycle(1, 8'h00, 0, A_MASK, 8'h00);
    cycle(0, 8'h00, 0, A_VEC, 8'h00);
    // Mask 05, pulse source 2
    cycle(0, 8'h00, 1, A_MASK, 8'h05);
    cycle(0, 8'h04, 0, A_STAT, 8'h00);
    cycle(0, 8'h00, 0, A_VEC, 8'h00);
    repeat (3) cycle(0, 8'h00, 0, A_STAT, 8'h00);
    // Two pending, priority then clear lower
    cycle(0, 8'h00, 1, A_MASK, 8'h0C);
    cycle(0, 8'h00, 1, A_FORCE, 8'h0C);
    cycle(0, 8'h00, 0, A_VEC, 8'h00);
    cycle(0, 8'h00, 1, A_STAT, 8'h04);
    repeat (2) cycle(0, 8'h00, 0, A_VEC, 8'h00);
    // Clear last source, re-pend inside holdoff
    cycle(0, 8'h00, 1, A_STAT, 8'h08);
    cycle(0, 8'h00, 0, A_VEC, 8'h00);
    cycle(0, 8'h00, 1, A_FORCE, 8'h08);
    repeat (10) cycle(0, 8'h00, 0, A_VEC, 8'h00);
    cycle(0, 8'h00, 1, A_STAT, 8'hFF);
    repeat (8) cycle(0, 8'h00, 0, A_STAT, 8'h00);
    // Rise and status clear in the same cycle
    cycle(0, 8'h00, 1, A_MASK, 8'h02);
    cycle(0, 8'h02, 1, A_STAT, 8'h02);
    cycle(0, 8'h02, 0, A_STAT, 8'h00);
    repeat (3) cycle(0, 8'h00, 0, A_STAT, 8'h00);
    cycle(0, 8'h00, 1, A_STAT, 8'hFF);
    repeat (7) cycle(0, 8'h00, 0, 8'h12, 8'h00);
    // Pending but masked, then force+mask bit 7
    cycle(0, 8'h00, 1, A_MASK, 8'h00);
    cycle(0, 8'h01, 0, A_STAT, 8'h00);
    repeat (3) cycle(0, 8'h00, 0, A_VEC, 8'h00);
    cycle(0, 8'h00, 1, A_FORCE, 8'h80);
    cycle(0, 8'h00, 1, A_MASK, 8'h80);
    repeat (3) cycle(0, 8'h00, 0, A_VEC, 8'h00);
    // Async reset while request asserted
    cycle(1, 8'h00, 0, A_STAT, 8'h00);
    cycle(1, 8'h00, 0, A_MASK, 8'h00);
    cycle(0, 8'h00, 0, A_VEC, 8'h00);

    // Randomized traffic
    irq_v = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) irq_v = irq_v ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) pid = 8'($urandom);
      else pid = A_STAT + 8'($urandom_range(0, 3));
      cycle($urandom_range(0, 499) == 0, irq_v, $urandom_range(0, 3) == 0, pid, 8'($urandom));
    end
    cycle(0, 8'h00, 0, A_STAT, 8'h00);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
